// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 multi-cycle core control path.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    ERR
  } seq_state_t;

  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts ready-less handshake cycles; expired flags the LIMIT-th such cycle.
// LIMIT = 0 disables expiry entirely.
module seq_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  generate
    if (LIMIT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = en && (cnt == W'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR.
// Optional perf counters (cycle_cnt, instret_cnt) with CORE_SEQ_PERF_CNT_EN.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic            branch,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  output logic            rf_we,
  output logic            halt
`ifdef CORE_SEQ_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
`endif
);

  seq_state_t      state;
  logic [XLEN-1:0] pc_q, ir_q, tgt_q;
  logic            take_q, store_q;

  logic            waiting, rdy, expired;
  logic            take_now, retire, bad_tgt;
  logic [XLEN-1:0] tgt_now, next_pc;

  // One timer serves both memory waits; only one handshake is ever open.
  assign waiting = (state == FETCH) || (state == MEM);
  assign rdy     = ((state == FETCH) && imem_ready) || ((state == MEM) && dmem_ready);

  seq_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!waiting || rdy),
    .en      (waiting && !rdy),
    .expired (expired)
  );

  // In EXEC the branch inputs are live; later the captured copies are used.
  always_comb begin
    take_now = (state == EXEC) ? (branch & branch_taken) : take_q;
    tgt_now  = (state == EXEC) ? branch_target : tgt_q;
    next_pc  = take_now ? tgt_now : pc_q + XLEN'(INST_BYTES);
    bad_tgt  = take_now && misaligned(tgt_now);
    retire   = 1'b0;
    case (state)
      EXEC:    retire = !(mem_read || mem_write || reg_write);
      MEM:     retire = dmem_ready && store_q;
      WB:      retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      tgt_q   <= '0;
      take_q  <= 1'b0;
      store_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            ir_q  <= imem_rdata;
            state <= DECODE;
          end else if (expired) begin
            state <= ERR;
          end
        end
        DECODE: state <= EXEC;
        EXEC: begin
          take_q  <= branch & branch_taken;
          tgt_q   <= branch_target;
          store_q <= mem_write;
          if (mem_read && mem_write)      state <= ERR;
          else if (mem_read || mem_write) state <= MEM;
          else if (reg_write)             state <= WB;
        end
        MEM: begin
          if (dmem_ready) begin
            if (!store_q) state <= WB;
          end else if (expired) begin
            state <= ERR;
          end
        end
        WB:      ;
        ERR:     ;
        default: state <= ERR;
      endcase
      if (retire) begin
        if (bad_tgt) begin
          state <= ERR;
        end else begin
          pc_q  <= next_pc;
          state <= FETCH;
        end
      end
    end
  end

  // imem_req is gated by rst_n so it is low for the whole reset interval.
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = ir_q;
  assign dmem_req  = (state == MEM);
  assign dmem_we   = (state == MEM) && store_q;
  assign rf_we     = (state == WB);
  assign halt      = (state == ERR);

`ifdef CORE_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != ERR)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (retire && !bad_tgt)
        instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the RV32 core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and owns the program counter and the instruction register. It also drives the instruction- and data-memory request/ready handshakes and strobes the register-file write. It sits between the memories and the combinational instruction decoder: it feeds the decoder `inst` and consumes the decoder's `mem_read`, `mem_write`, `reg_write` and `branch` flags.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `MEM_TIMEOUT`, default 15: maximum wait cycles on a memory handshake before error; 0 disables the timeout.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ready`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  32  fetched instruction.
- `inst`  out  32  instruction register, to the decoder.
- `pc`  out  32  current instruction address.
- `mem_read`, `mem_write`, `reg_write`, `branch`  in  1 each  decoder flags for `inst`.
- `branch_taken`  in  1  branch condition from the ALU; valid in EXEC.
- `branch_target`  in  32  target address; valid in EXEC.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req` is high.
- `dmem_ready`  in  1  data access complete this cycle.
- `rf_we`  out  1  register-file write strobe, one cycle.
- `halt`  out  1  sticky error/halt flag.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, ERR.
- FETCH: `imem_req`=1. On `imem_ready`: IR ← `imem_rdata`, go to DECODE.
- DECODE: one cycle, so the decoder outputs settle from IR. Then go to EXEC.
- EXEC: one cycle.
  - `mem_read|mem_write` → MEM.
  - Otherwise `reg_write` → WB.
  - Otherwise → FETCH with PC update.
  - `mem_read` and `mem_write` both high → ERR.
- MEM: `dmem_req`=1, `dmem_we`=`mem_write`. On `dmem_ready`: load → WB; store → FETCH with PC update.
- WB: `rf_we`=1 for exactly one cycle, then → FETCH with PC update.
- PC update on every transition into FETCH:
  - `branch & branch_taken` → `branch_target`.
  - Otherwise → `pc`+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - `branch_taken` and `branch_target` are captured in EXEC and held until the update.
- Misaligned taken target (`branch_target[1:0]`≠0) → ERR; PC is not updated.
- Handshake rules:
  - A request stays high with a stable address until the matching ready.
  - Ready is sampled only while the request is high; ready with the request low is ignored.
  - Ready in the same cycle the request rises completes the access.
- Timeout: a wait counter counts FETCH/MEM cycles without ready. When it reaches `MEM_TIMEOUT` → ERR. The counter clears on every state change.
- ERR: all requests and `rf_we` low, `halt`=1. ERR is terminal until reset.
- Reset, async and possibly mid-operation:
  - State → FETCH, `pc`=`RESET_PC`, IR=0, `halt`=0, counters 0.
  - All request/strobe outputs drop immediately.
  - An in-flight memory response is discarded.

## Timing
- Reset values: `imem_req`=1 once reset is released (0 while `rst_n`=0), `imem_addr`=`pc`=`RESET_PC`, `inst`=0, `dmem_req`=0, `dmem_we`=0, `rf_we`=0, `halt`=0.
- Cycles per instruction with zero-wait memory:
  - ALU / immediate: 4 (F, D, E, W).
  - Load: 5.
  - Store: 4.
  - Branch or no-write instruction: 3.
- Each wait cycle adds one cycle.
- `rf_we` is asserted in WB. The regfile commits on the rising edge at the end of WB.
- The next `imem_req` is asserted in the cycle after WB, MEM-store completion or EXEC, using the updated PC.
- A stall equal to `MEM_TIMEOUT` ready-less cycles leads to `halt`=1 on the following cycle.

## Configuration
- `CORE_SEQ_PERF_CNT_EN` defined: adds outputs `cycle_cnt` (32) and `instret_cnt` (32), both reset to 0.
  - `cycle_cnt` increments every cycle outside ERR.
  - `instret_cnt` increments on each transition into FETCH from EXEC, MEM or WB.
  - Both wrap at 2^32.
- Not defined: the ports and counters are absent. Sequencing is identical.

## Structure
- Shared package `core_pkg`: state enum `seq_state_t`, `XLEN`=32, `INST_BYTES`=4, opcode constants (R-type 7'b0110011, I-type 7'b0010011, LOAD, STORE, BRANCH).
- One sub-module, `seq_wait_timer`: parameterised wait counter with clear, enable and `expired` output. It is reused for both FETCH and MEM waits.

## Test plan
- Reset with `RESET_PC`=0x100, `imem_ready` tied high, ADDI fetched → `imem_addr`=0x100; `rf_we` pulses in the 4th cycle; next fetch address 0x104.
- Load with `dmem_ready` delayed 3 cycles → `dmem_req` held 4 cycles with `dmem_we`=0; `rf_we` one cycle later; 8 cycles total.
- Taken branch to 0x40 → next `imem_addr`=0x40. Target 0x42 → `halt`=1, all requests low.
- `imem_ready` never asserted with `MEM_TIMEOUT`=15 → `halt` rises after 15 wait cycles and stays high until `rst_n` is pulsed.
- `rst_n` asserted low in the middle of MEM → `dmem_req` drops immediately; after release, fetch resumes at `RESET_PC`; a late `dmem_ready` is ignored.
- PC at 0xFFFF_FFFC running an ADD → next fetch address 0x0. With `CORE_SEQ_PERF_CNT_EN`, `instret_cnt` increments by 1.
